// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit tick timer with prescale normalisation and 3-sample majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_run,
    input  logic                   i_rx,
    input  logic [PRESC_WIDTH-1:0] i_prescale,
    output logic                   bit_done,
    output logic                   bit_val
);
    localparam logic [PRESC_WIDTH-1:0] P_MIN = PRESC_WIDTH'(MIN_PRESCALE);

    logic [PRESC_WIDTH-1:0] w_p_even;
    logic [PRESC_WIDTH-1:0] w_p;
    logic [PRESC_WIDTH-1:0] w_half;
    logic [PRESC_WIDTH-1:0] r_rem;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_s2;
    logic                   w_s2;

    assign w_p_even = i_prescale & ~PRESC_WIDTH'(1);
    assign w_p      = (w_p_even < P_MIN) ? P_MIN : w_p_even;
    assign w_half   = w_p >> 1;

    // Down-counter holds ticks remaining in the bit; the detection cycle is tick 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_s0  <= 1'b1;
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
        end else if (i_start) begin
            r_rem <= w_p - PRESC_WIDTH'(2);
        end else if (i_run) begin
            r_rem <= (r_rem == '0) ? w_p - PRESC_WIDTH'(1) : r_rem - PRESC_WIDTH'(1);
            if (r_rem == w_half)                    r_s0 <= i_rx;
            if (r_rem == w_half - PRESC_WIDTH'(1))  r_s1 <= i_rx;
            if (r_rem == w_half - PRESC_WIDTH'(2))  r_s2 <= i_rx;
        end
    end

    // At P=4 the third sample lands on the last tick, so it bypasses its register.
    assign w_s2     = (r_rem == w_half - PRESC_WIDTH'(2)) ? i_rx : r_s2;
    assign bit_done = i_run && (r_rem == '0);
    assign bit_val  = maj3(r_s0, r_s1, w_s2);
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop checks.
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | validating start bit (voted 1 = glitch)
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | checking parity bit against latched type
// STOP   | one or two stop bits, frame resolved on the last
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   STOP2,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   Data_Valid,
    output logic                   Par_Err,
    output logic                   Stp_Err,
    output logic                   Busy
);
    localparam int BCW = $clog2(DATA_WIDTH);

    rx_state_e              r_state;
    rx_state_e              w_next;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [PRESC_WIDTH-1:0] w_presc;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic                   r_stop2;
    logic [BCW-1:0]         r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_par_bad;
    logic                   r_stp_bad;
    logic                   w_start;
    logic                   w_bit_done;
    logic                   w_bit_val;
    logic                   w_exp_par;
    logic                   w_frame_end;
    logic                   w_stp_bad;

    assign w_start = (r_state == S_IDLE) && !RX_IN;
    // The sampler must see the live prescale in the detection cycle, before it is latched.
    assign w_presc = w_start ? Prescale : r_presc;

    uart_rx_sampler #(.PRESC_WIDTH(PRESC_WIDTH)) u_sampler (
        .clk        (CLK),
        .rst_n      (RST),
        .i_start    (w_start),
        .i_run      (r_state != S_IDLE),
        .i_rx       (RX_IN),
        .i_prescale (w_presc),
        .bit_done   (w_bit_done),
        .bit_val    (w_bit_val)
    );

    assign w_exp_par   = (^r_shift) ^ (r_par_typ == PAR_ODD);
    assign w_frame_end = (r_state == S_STOP) && w_bit_done && (!r_stop2 || r_stop_cnt);
    assign w_stp_bad   = r_stp_bad | ~w_bit_val;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!RX_IN) w_next = S_START;
            S_START:  if (w_bit_done) w_next = w_bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_done && r_bit_cnt == BCW'(DATA_WIDTH - 1))
                          w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_done) w_next = S_STOP;
            S_STOP:   if (w_frame_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Busy       <= (w_next != S_IDLE);
            if (w_start) begin
                r_presc    <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_stop2    <= STOP2;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_par_bad  <= 1'b0;
                r_stp_bad  <= 1'b0;
            end
            if (r_state == S_DATA && w_bit_done) begin
                r_shift   <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            if (r_state == S_PARITY && w_bit_done)
                r_par_bad <= (w_bit_val != w_exp_par);
            if (r_state == S_STOP && w_bit_done) begin
                r_stop_cnt <= 1'b1;
                r_stp_bad  <= w_stp_bad;
            end
            if (w_frame_end) begin
                Par_Err <= r_par_bad;
                Stp_Err <= w_stp_bad;
                if (!r_par_bad && !w_stp_bad) begin
                    P_DATA     <= r_shift;
                    Data_Valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized frames against a frame-level reference model.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(16);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;
    logic          Busy;

    int n_cmp = 0;
    int n_fail = 0;
    int n_dv = 0;
    int n_pe = 0;
    int n_se = 0;
    logic [DW-1:0] m_pdata = '0;

    uart_rx_param #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Data_Valid === 1'b1) n_dv++;
        if (Par_Err === 1'b1)    n_pe++;
        if (Stp_Err === 1'b1)    n_se++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int eff_p(input int raw);
        int e;
        e = raw - (raw % 2);
        return (e < MIN_PRESCALE) ? MIN_PRESCALE : e;
    endfunction

    // scramble: 0 none, 1 random config after detection, 2 Prescale forced to 4 after detection
    task automatic send_frame(input int praw, input logic [7:0] d, input bit pen, input bit ptyp,
                              input bit s2, input bit par_bad, input bit stp1_bad, input bit stp2_bad,
                              input int spike_k, input int spike_t, input int scramble, input string tag);
        int p;
        bit bits[$];
        bit pbit;
        bit par_ok;
        bit stp_ok;
        p = eff_p(praw);
        Prescale = PW'(praw);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = s2;
        pbit = (^d) ^ ptyp ^ par_bad;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(!stp1_bad);
        if (s2) bits.push_back(!stp2_bad);
        chk({tag, " busy_before"}, Busy, 0);
        for (int k = 0; k < bits.size(); k++) begin
            for (int t = 0; t < p; t++) begin
                RX_IN = (k == spike_k && t == spike_t) ? !bits[k] : bits[k];
                step();
                if (k == 0 && t == 0) begin
                    chk({tag, " busy_rise"}, Busy, 1);
                    if (scramble == 1) begin
                        Prescale = PW'($urandom_range(0, 63));
                        PAR_EN   = 1'($urandom);
                        PAR_TYP  = 1'($urandom);
                        STOP2    = 1'($urandom);
                    end else if (scramble == 2) begin
                        Prescale = PW'(4);
                    end
                end
            end
        end
        RX_IN = 1'b1;
        par_ok = !pen || (pbit == ((^d) ^ ptyp));
        stp_ok = !stp1_bad && !(s2 && stp2_bad);
        if (par_ok && stp_ok) m_pdata = d;
        chk({tag, " data_valid"}, Data_Valid, par_ok && stp_ok);
        chk({tag, " par_err"}, Par_Err, !par_ok);
        chk({tag, " stp_err"}, Stp_Err, !stp_ok);
        chk({tag, " p_data"}, P_DATA, m_pdata);
        chk({tag, " busy_fall"}, Busy, 0);
    endtask

    task automatic gap_check(input string tag);
        step();
        chk({tag, " strobe_width"}, {Data_Valid, Par_Err, Stp_Err}, 3'b000);
    endtask

    initial begin
        int c_dv;
        int c_pe;
        int c_se;
        logic [7:0] dpart;

        repeat (3) step();
        chk("reset p_data", P_DATA, 0);
        chk("reset strobes", {Data_Valid, Par_Err, Stp_Err}, 3'b000);
        chk("reset busy", Busy, 0);
        RST = 1'b1;
        repeat (2) step();

        send_frame(16, 8'hF0, 0, 0, 0, 0, 0, 0, -1, 0, 0, "f0_nopar");
        gap_check("f0_nopar");
        repeat (3) step();

        send_frame(16, 8'hF0, 1, 1, 0, 0, 0, 0, -1, 0, 0, "b2b_odd");
        send_frame(16, 8'h55, 1, 0, 0, 0, 0, 0, -1, 0, 0, "b2b_even");
        gap_check("b2b_even");

        send_frame(16, 8'hAA, 1, 1, 0, 1, 0, 0, -1, 0, 0, "par_err");
        gap_check("par_err");
        send_frame(16, 8'hAA, 1, 1, 0, 0, 1, 0, -1, 0, 0, "stp_err");
        gap_check("stp_err");
        repeat (2) step();

        // Short low pulse on the idle line
        c_dv = n_dv; c_pe = n_pe; c_se = n_se;
        Prescale = PW'(16);
        RX_IN = 1'b0;
        repeat (4) step();
        RX_IN = 1'b1;
        repeat (12) step();
        chk("glitch busy", Busy, 0);
        repeat (4) step();
        chk("glitch strobes", (n_dv - c_dv) + (n_pe - c_pe) + (n_se - c_se), 0);

        send_frame(16, 8'h00, 0, 0, 0, 0, 0, 0, 4, 8, 0, "spike");
        gap_check("spike");

        send_frame(8, 8'h0F, 0, 0, 1, 0, 0, 1, -1, 0, 0, "stop2_err");
        gap_check("stop2_err");
        send_frame(8, 8'h0F, 1, 0, 1, 0, 0, 0, -1, 0, 0, "stop2_ok");
        send_frame(32, 8'h96, 1, 1, 0, 0, 0, 0, -1, 0, 2, "presc_latch");
        gap_check("presc_latch");
        send_frame(3, 8'h3C, 0, 0, 0, 0, 0, 0, -1, 0, 0, "presc3");
        gap_check("presc3");

        // Reset in the middle of a frame
        Prescale = PW'(16); PAR_EN = 1'b0; STOP2 = 1'b0;
        c_dv = n_dv; c_pe = n_pe; c_se = n_se;
        dpart = 8'h3C;
        RX_IN = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 3; i++) begin
            RX_IN = dpart[i];
            repeat (16) step();
        end
        RST = 1'b0;
        step();
        m_pdata = '0;
        chk("midreset p_data", P_DATA, m_pdata);
        chk("midreset busy", Busy, 0);
        RX_IN = 1'b1;
        step();
        RST = 1'b1;
        repeat (200) step();
        chk("midreset strobes", (n_dv - c_dv) + (n_pe - c_pe) + (n_se - c_se), 0);
        send_frame(16, 8'hA5, 0, 0, 0, 0, 0, 0, -1, 0, 0, "after_reset");
        gap_check("after_reset");

        for (int i = 0; i < 40; i++) begin
            int praw;
            logic [7:0] d;
            bit pen, ptyp, s2, pb, sb1, sb2;
            praw = $urandom_range(3, 21);
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            s2   = 1'($urandom);
            pb   = ($urandom_range(0, 3) == 0);
            sb1  = ($urandom_range(0, 3) == 0);
            sb2  = ($urandom_range(0, 3) == 0);
            send_frame(praw, d, pen, ptyp, s2, pb, sb1, sb2, -1, 0, 1, "rnd");
            if ($urandom_range(0, 1) == 1) gap_check("rnd");
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver; successor to the fixed 8-bit receiver. It adds:
- configurable data width and prescale width;
- 3-sample majority-vote bit recovery;
- optional two stop bits;
- per-frame configuration latching;
- explicit parity-error and stop-error strobes.

It sits between the asynchronous serial pin (already synchronised upstream) and the parallel consumer, which reads `P_DATA` on `Data_Valid`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `PRESC_WIDTH`, default 6: width of `Prescale`.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, idle high.
- `Prescale`  in  PRESC_WIDTH  clocks per bit. Values are forced even (bit 0 ignored); values below 4 are treated as 4.
- `PAR_EN`  in  1  parity bit present.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `STOP2`  in  1  two stop bits expected.
- `P_DATA`  out  DATA_WIDTH  last good frame.
- `Data_Valid`  out  1  one-cycle strobe: `P_DATA` has been updated.
- `Par_Err`  out  1  one-cycle strobe: parity mismatch.
- `Stp_Err`  out  1  one-cycle strobe: a stop bit sampled low.
- `Busy`  out  1  high in every state except IDLE.

## Operation
States and transitions:
- IDLE: `RX_IN`=0 moves to START. The detection cycle counts as tick 0. `Prescale`, `PAR_EN`, `PAR_TYP` and `STOP2` are latched in that same cycle. Later changes to these inputs take effect only from the next frame.
- START: at the last tick, a voted value of 1 is a glitch → IDLE with no strobes. A voted 0 → DATA.
- DATA: DATA_WIDTH bits are shifted in LSB first. Then → PARITY if `PAR_EN` latched high, else → STOP.
- PARITY: the voted bit is compared against XOR(data) ^ latched `PAR_TYP`. A mismatch sets an internal error flag.
- STOP: one stop bit, or two if `STOP2` is latched. Any stop bit voted 0 sets the stop-error flag.
  - At the last tick of the final stop bit, the frame is resolved (see below) and the FSM → IDLE.

Bit recovery:
- The tick counter runs 0..P-1 per bit, where P is the effective prescale.
- `RX_IN` is sampled at ticks P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples.

Frame resolution:
- No error: `P_DATA` ← shift register and `Data_Valid` pulses.
- Parity error: `Par_Err` pulses.
- Stop error: `Stp_Err` pulses.
- Both errors: both strobes pulse together.
- On any error `P_DATA` is unchanged and `Data_Valid` stays low.

Other rules:
- Back-to-back frames: IDLE is reached at the tick after the final stop-bit tick. A start bit beginning right then is accepted (at most 1 cycle of phase lag). The phase resyncs on every start edge.
- `P_DATA` holds its value until the next good frame.

## Timing
- Reset values: `P_DATA`=0, `Data_Valid`=`Par_Err`=`Stp_Err`=0, `Busy`=0, FSM=IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately; no strobe is issued after release.
- Frame length in cycles is P×(1+DATA_WIDTH+PAR_EN+1+STOP2).
- Strobe timing: each strobe is registered high in the cycle after the final stop-bit tick, for exactly 1 cycle.
- Latency: the strobe is high in the same cycle that `Busy` falls.
- `Busy` rises in the cycle after detection.
- Glitch: a low pulse shorter than P/2-1 cycles never reaches DATA.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `PAR_EVEN`/`PAR_ODD` constants;
  - `MIN_PRESCALE`=4.
- Sub-module `uart_rx_sampler`:
  - owns the tick counter, prescale normalisation and the 3-sample majority voter;
  - outputs `bit_done` (last tick) and `bit_val` (voted value).
- The top level holds the FSM, bit counter, shift register, parity/stop checks and output registers.

## Test plan
- P=16, no parity, 1 stop, data 0xF0 → `Data_Valid` 1-cycle pulse, `P_DATA`=0xF0, `Busy` low in the same cycle.
- P=16, odd parity bit 1 with 0xF0, then even parity 0 with 0x55 sent back-to-back → two `Data_Valid` pulses, 0xF0 then 0x55, with no errors.
- P=16, 0xAA, odd parity bit 0 → `Par_Err` pulse, `P_DATA` still 0x55. Then stop bit 0 with correct parity → `Stp_Err` pulse only.
- Glitches:
  - 4-cycle low on the idle line at P=16 → no strobes, `Busy` back to 0 by tick 16.
  - Single-cycle low spike at tick P/2 inside data bit 3 of 0x00 → `P_DATA`=0x00 (vote rejects the spike).
- Configuration:
  - `STOP2`=1, P=8, 0x0F, second stop bit 0 → `Stp_Err`.
  - `Prescale` changed 32→4 mid-frame → the frame still decodes at 32.
  - `Prescale`=3 → behaves as 4.
- Reset during DATA of 0x3C → no strobes, `P_DATA` reads 0. The next frame 0xA5 decodes correctly.
